// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared types and constants for the burst responder (stall option: MEM_RESP_STALL_EN)
package mem_resp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    WR_WAIT,
    RD_RESP,
    WR_RESP,
    GAP
  } state_t;

  localparam int BEAT_BYTES = 16;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // x^8+x^6+x^5+x^4+1 as a left-shifting Fibonacci register
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mem_resp_array.sv
// rtl/mem_resp_array.sv - beat store with asynchronous read and byte-masked synchronous write
module mem_resp_array
  import mem_resp_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int BEAT_W = 8 * BEAT_BYTES,
  parameter int IW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wen,
  input  logic [IW-1:0]     waddr,
  input  logic [BEAT_W-1:0] wdata,
  input  logic [BEAT_W/8-1:0] wmask,
  input  logic [IW-1:0]     raddr,
  output logic [BEAT_W-1:0] rdata
);

  logic [BEAT_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wen) begin
      for (int i = 0; i < BEAT_W / 8; i++) begin
        if (wmask[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_burst_responder.sv
// rtl/mem_burst_responder.sv - fixed-latency memory responder for 128-bit beats
// Define MEM_RESP_STALL_EN to add 0-3 pseudo-random extra wait cycles per beat.
module mem_burst_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ren_mem,
  input  logic [ADDR_WIDTH-1:0]     raddr_mem,
  output logic                      rvalid_mem,
  output logic [2*DATA_WIDTH-1:0]   rdata_mem,
  input  logic                      wen_mem,
  input  logic [ADDR_WIDTH-1:0]     waddr_mem,
  input  logic [2*DATA_WIDTH-1:0]   wdata_mem,
  input  logic [2*DATA_WIDTH/8-1:0] wmask_mem,
  output logic                      wvalid_mem
);

  localparam int BW = 2 * DATA_WIDTH;
  localparam int MW = BW / 8;
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 4);

  state_t          state;
  logic [IW-1:0]   idx;
  logic [BW-1:0]   wdata_q;
  logic [MW-1:0]   wmask_q;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_load;
  logic [BW-1:0]   arr_rdata;
  logic [1:0]      extra;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{raddr_mem[ADDR_WIDTH-1:IW+4], raddr_mem[3:0],
                              waddr_mem[ADDR_WIDTH-1:IW+4], waddr_mem[3:0]};

`ifdef MEM_RESP_STALL_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= lfsr_next(lfsr);
  end

  assign extra = lfsr[1:0];
`else
  assign extra = 2'b00;
`endif

  // Counter counts down to zero; the cycle it reads zero is the last wait cycle.
  assign cnt_load = CW'(LATENCY - 1) + CW'(extra);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rvalid_mem <= 1'b0;
      wvalid_mem <= 1'b0;
      rdata_mem  <= '0;
      cnt        <= '0;
      idx        <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
    end else begin
      rvalid_mem <= 1'b0;
      wvalid_mem <= 1'b0;
      case (state)
        IDLE: begin
          if (ren_mem) begin
            idx   <= raddr_mem[IW+3:4];
            cnt   <= cnt_load;
            state <= RD_WAIT;
          end else if (wen_mem) begin
            idx     <= waddr_mem[IW+3:4];
            wdata_q <= wdata_mem;
            wmask_q <= wmask_mem;
            cnt     <= cnt_load;
            state   <= WR_WAIT;
          end
        end
        RD_WAIT: begin
          if (!ren_mem) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            state      <= RD_RESP;
            rvalid_mem <= 1'b1;
            rdata_mem  <= arr_rdata;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WR_WAIT: begin
          if (!wen_mem) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            state      <= WR_RESP;
            wvalid_mem <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RD_RESP: state <= GAP;
        WR_RESP: state <= GAP;
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The store commits during WR_RESP, so any later read capture sees the new data.
  mem_resp_array #(
    .DEPTH (DEPTH),
    .BEAT_W(BW),
    .IW    (IW)
  ) u_array (
    .clk  (clk),
    .wen  (state == WR_RESP),
    .waddr(idx),
    .wdata(wdata_q),
    .wmask(wmask_q),
    .raddr(idx),
    .rdata(arr_rdata)
  );

endmodule

// File: tb/tb_mem_burst_responder.sv
// tb/tb_mem_burst_responder.sv - directed scoreboard bench for mem_burst_responder
module tb_mem_burst_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic         ren_mem;
  logic [63:0]  raddr_mem;
  logic         rvalid_mem;
  logic [127:0] rdata_mem;
  logic         wen_mem;
  logic [63:0]  waddr_mem;
  logic [127:0] wdata_mem;
  logic [15:0]  wmask_mem;
  logic         wvalid_mem;

  mem_burst_responder dut (
    .clk       (clk),
    .rst       (rst),
    .ren_mem   (ren_mem),
    .raddr_mem (raddr_mem),
    .rvalid_mem(rvalid_mem),
    .rdata_mem (rdata_mem),
    .wen_mem   (wen_mem),
    .waddr_mem (waddr_mem),
    .wdata_mem (wdata_mem),
    .wmask_mem (wmask_mem),
    .wvalid_mem(wvalid_mem)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           rd;
    logic [127:0] data;
    int           cyc;
  } exp_t;

  exp_t         sbq[$];
  logic [127:0] model[int];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int beat_of(input logic [63:0] addr);
    return int'((addr >> 4) & 64'd1023);
  endfunction

  function automatic void model_write(input logic [63:0] addr, input logic [127:0] d, input logic [15:0] m);
    logic [127:0] cur;
    cur = model.exists(beat_of(addr)) ? model[beat_of(addr)] : 'x;
    for (int i = 0; i < 16; i++) if (m[i]) cur[i*8 +: 8] = d[i*8 +: 8];
    model[beat_of(addr)] = cur;
  endfunction

  // Steps until a response pulse appears, then checks it against the head of the scoreboard.
  task automatic expect_pulse(input string tag);
    exp_t e;
    bit   seen;
    e = sbq.pop_front();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (rvalid_mem || wvalid_mem) seen = 1'b1;
    end
    check({tag, "_seen"}, 128'(seen), 128'd1);
    if (seen) begin
      check({tag, "_kind"}, {126'd0, rvalid_mem, wvalid_mem}, e.rd ? 128'd2 : 128'd1);
      check({tag, "_cycle"}, 128'(cyc), 128'(e.cyc));
      if (e.rd) check({tag, "_data"}, rdata_mem, e.data);
    end
  endtask

  task automatic gap_then_idle(input string tag);
    step();
    check({tag, "_gap_quiet"}, {126'd0, rvalid_mem, wvalid_mem}, 128'd0);
    step();
  endtask

  task automatic do_write(input string tag, input logic [63:0] a, input logic [127:0] d, input logic [15:0] m);
    wen_mem = 1'b1; waddr_mem = a; wdata_mem = d; wmask_mem = m;
    sbq.push_back('{rd: 1'b0, data: '0, cyc: cyc + 3});
    model_write(a, d, m);
    expect_pulse(tag);
    wen_mem = 1'b0;
    gap_then_idle(tag);
  endtask

  task automatic do_read(input string tag, input logic [63:0] a);
    ren_mem = 1'b1; raddr_mem = a;
    sbq.push_back('{rd: 1'b1, data: model[beat_of(a)], cyc: cyc + 3});
    expect_pulse(tag);
    ren_mem = 1'b0;
    gap_then_idle(tag);
  endtask

  initial begin
    logic [127:0] pat;
    int t0;
    int pulses;

    rst = 1'b1; ren_mem = 1'b0; wen_mem = 1'b0;
    raddr_mem = '0; waddr_mem = '0; wdata_mem = '0; wmask_mem = '0;
    step(); step();
    check("reset_rvalid", 128'(rvalid_mem), 128'd0);
    check("reset_wvalid", 128'(wvalid_mem), 128'd0);
    check("reset_rdata", rdata_mem, 128'd0);
    rst = 1'b0;
    step();

    // full write then read-back
    pat = 128'h00112233445566778899AABBCCDDEEFF;
    do_write("wr40", 64'h40, pat, 16'hFFFF);
    do_read("rd40", 64'h40);
    check("rd40_const", model[4], pat);

    // burst of three beats, address stepped right after each pulse
    for (int i = 0; i < 3; i++)
      do_write("fill", 64'h100 + 64'(16 * i), {4{32'hB0B00000 + 32'(i)}}, 16'hFFFF);
    t0 = cyc;
    ren_mem = 1'b1; raddr_mem = 64'h100;
    for (int i = 0; i < 3; i++)
      sbq.push_back('{rd: 1'b1, data: {4{32'hB0B00000 + 32'(i)}}, cyc: t0 + 3 + 5 * i});
    for (int i = 0; i < 3; i++) begin
      expect_pulse("burst");
      raddr_mem = raddr_mem + 64'd16;
      if (i == 2) ren_mem = 1'b0;
    end
    check("burst_len", 128'(cyc - t0), 128'd13);
    gap_then_idle("burst");

    // partial write over a zeroed beat
    do_write("zero", 64'h300, 128'd0, 16'hFFFF);
    do_write("part", 64'h300, {16{8'hAA}}, 16'h00F0);
    do_read("rdpart", 64'h300);
    check("part_const", model[beat_of(64'h300)], 128'h0000000000000000_AAAAAAAA_00000000);

    // simultaneous requests: read first, write 5 cycles later
    t0 = cyc;
    ren_mem = 1'b1; raddr_mem = 64'h40;
    wen_mem = 1'b1; waddr_mem = 64'h200; wdata_mem = {8{16'h5A5A}}; wmask_mem = 16'hFFFF;
    sbq.push_back('{rd: 1'b1, data: model[4], cyc: t0 + 3});
    sbq.push_back('{rd: 1'b0, data: '0, cyc: t0 + 8});
    model_write(64'h200, {8{16'h5A5A}}, 16'hFFFF);
    expect_pulse("both_rd");
    ren_mem = 1'b0;
    expect_pulse("both_wr");
    wen_mem = 1'b0;
    gap_then_idle("both");
    do_read("rd200", 64'h200);

    // read aborted in cycle 1
    ren_mem = 1'b1; raddr_mem = 64'h40;
    step();
    ren_mem = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rvalid_mem) pulses++;
    end
    check("abort_no_rvalid", 128'(pulses), 128'd0);

    // reset during WR_WAIT discards the write
    wen_mem = 1'b1; waddr_mem = 64'h40; wdata_mem = {16{8'h77}}; wmask_mem = 16'hFFFF;
    step();
    rst = 1'b1;
    #1;
    check("rst_wvalid_now", 128'(wvalid_mem), 128'd0);
    step();
    rst = 1'b0; wen_mem = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (wvalid_mem) pulses++;
    end
    check("rst_no_wvalid", 128'(pulses), 128'd0);
    do_read("rd40_after_rst", 64'h40);

    // upper address bits ignored: 0x4040 aliases beat 4
    do_write("wr4040", 64'h4040, {2{64'hFEEDFACE_CAFEBEEF}}, 16'hFFFF);
    do_read("rd40_alias", 64'h40);
    check("alias_const", model[4], {2{64'hFEEDFACE_CAFEBEEF}});

    check("sb_empty", 128'(sbq.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
